// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues fixed-latency imem requests,
// and buffers returned instructions with their PCs for decode. Redirects flush all work.
module fetch_queue_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = 'h4000_0000,
    parameter int              DEPTH        = 4,
    parameter int              IMEM_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    output logic                     dec_valid,
    output logic [XLEN-1:0]          dec_instr,
    output logic [XLEN-1:0]          dec_pc,
    input  logic                     dec_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            tag_valid [IMEM_LATENCY];
    logic [XLEN-1:0] tag_pc    [IMEM_LATENCY];

    logic [CW-1:0]   inflight;
    logic [CW:0]     credit_sum;
    logic            issue;
    logic            push;
    logic            pop;

    // Credit counts every outstanding request, including the one returning this
    // cycle, so a response can never land on a full queue.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < IMEM_LATENCY; i++) begin
            inflight = inflight + CW'(tag_valid[i]);
        end
    end

    assign credit_sum = {1'b0, count} + {1'b0, inflight};
    assign issue      = !reset && !redirect_valid && (credit_sum < (CW+1)'(DEPTH));
    assign push       = tag_valid[IMEM_LATENCY-1] && !redirect_valid;
    assign dec_valid  = (count != '0) && !reset;
    assign pop        = dec_valid && dec_ready && !redirect_valid;

    assign imem_req   = issue;
    assign imem_addr  = fetch_pc;
    assign dec_instr  = dec_valid ? q_instr[rd_ptr] : '0;
    assign dec_pc     = dec_valid ? q_pc[rd_ptr]    : '0;
    assign occupancy  = reset ? '0 : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC & WORD_MASK;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < IMEM_LATENCY; i++) begin
                tag_valid[i] <= 1'b0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & WORD_MASK;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < IMEM_LATENCY; i++) begin
                tag_valid[i] <= 1'b0;
            end
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            tag_valid[0] <= issue;
            tag_pc[0]    <= fetch_pc;
            for (int i = 1; i < IMEM_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_pc[i]    <= tag_pc[i-1];
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= tag_pc[IMEM_LATENCY-1];
        end
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end for the riscv_core pipeline. It owns the fetch PC, issues word requests to a fixed-latency synchronous instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue. Decode drains the queue through a valid/ready handshake. Branch and jump redirects from decode flush the queue and any in-flight fetches, so decode back-pressure no longer gates the PC register directly.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h4000_0000, first fetch address after reset
DEPTH, 4, queue entries; power of two, >= 2
IMEM_LATENCY, 1, cycles from request to imem_rdata valid; legal values 1 or 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  decode-resolved branch/jump taken
redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored and forced to 0
imem_req  out  1  request issued this cycle
imem_addr  out  XLEN  word address of the request, bits [1:0] = 0
imem_rdata  in  XLEN  instruction, valid IMEM_LATENCY cycles after its request
dec_valid  out  1  queue head holds a valid instruction
dec_instr  out  XLEN  head instruction
dec_pc  out  XLEN  PC of the head instruction
dec_ready  in  1  decode accepts the head this cycle
occupancy  out  $clog2(DEPTH)+1  current queue entry count

Behaviour:
- Reset: reset and clk are as stated in Ports (synchronous, active-high). While reset is high: fetch_pc <= RESET_PC; queue count, read pointer and write pointer cleared; all in-flight tags cleared. Outputs during and immediately after reset: imem_req=0, dec_valid=0, occupancy=0, dec_instr=0, dec_pc=0.
- Reset mid-operation: discards everything. Nothing issued before reset may ever appear on dec_*.
- Issue condition:
  - imem_req = !reset && !redirect_valid && (count + inflight < DEPTH).
  - inflight = number of valid tags in an IMEM_LATENCY-deep tag shift register.
  - The credit check ignores a same-cycle pop (conservative).
  - imem_addr = fetch_pc combinationally. On issue, fetch_pc <= fetch_pc + 4 (wraps modulo 2^XLEN).
- Tag pipe: each issue pushes {valid=1, pc} into the tag shift register; non-issue cycles push valid=0.
- Response: when the tag exiting the pipe is valid, imem_rdata and the tag PC are written at the queue write pointer and count increments. The write is at the clock edge ending cycle t+IMEM_LATENCY for a request issued in cycle t.
- Fetch-to-decode latency: dec_valid rises in cycle t+IMEM_LATENCY+1. There is no bypass.
- Handshake:
  - dec_valid = (count != 0). dec_instr and dec_pc come from the head entry and are stable while dec_valid && !dec_ready.
  - pop = dec_valid && dec_ready && !redirect_valid.
  - A simultaneous push and pop leaves count unchanged.
- Full: the credit rule guarantees no push ever arrives when count == DEPTH. The bench asserts this.
- Redirect (cycle r):
  - No request is issued in cycle r.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Queue is emptied (count, pointers <= 0) and all tag valid bits are cleared, including any response returning in cycle r.
  - No pop occurs, regardless of dec_ready.
  - Cycle r+1: imem_req=1 at the new target. First new instruction reaches dec_valid in cycle r+1+IMEM_LATENCY+1.
- Back-to-back redirects: the last one wins; each cancels all prior work.
- Pointers wrap modulo DEPTH. occupancy = count.

Test Plan:
- Reset, DEPTH=4, L=1, dec_ready=1 held, imem returns addr^32'hFFFF_0000 -> imem_addr steps 0x4000_0000, 0x4000_0004, ... one per cycle. First dec_valid 2 cycles after reset falls, dec_pc=0x4000_0000. Then one instruction per cycle with no gaps.
- dec_ready=0 from reset -> exactly 4 requests issued, occupancy saturates at 4, imem_req stays 0. Release dec_ready -> heads emerge in order 0x4000_0000..0x4000_000C with no loss or duplication, then issue resumes at 0x4000_0010.
- Stream running, redirect_valid=1 with redirect_pc=0x4000_0103 while 1 response is in flight and 2 entries are queued -> next dec_pc is 0x4000_0100. No stale PC ever appears. imem_req=0 in the redirect cycle.
- Redirect and dec_ready=1 in the same cycle with dec_valid=1 -> the head is not consumed, dec_valid=0 next cycle, occupancy=0.
- DEPTH=2, IMEM_LATENCY=2, dec_ready toggling 1,0,1,0 -> count+inflight never exceeds 2, the queue never overflows, and dec_pc increments by exactly 4 on each accepted handshake.
- Assert reset for one cycle while the queue is full and a request is in flight -> the next dec_valid carries dec_pc=0x4000_0000. No pre-reset instruction appears.
